// File: rtl/jtlabrun_romarb_pkg.sv
// Shared types and defaults for the Labyrinth Runner SDRAM read arbiter.
// Holds the sequencer states, the owner encoding and the default SDRAM offsets.
package jtlabrun_romarb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_e;

    typedef enum logic {
        GFX  = 1'b0,
        MAIN = 1'b1
    } owner_e;

    localparam logic [21:0] GFX_OFFSET_DEF  = 22'h1_0000;
    localparam logic [21:0] MAIN_OFFSET_DEF = 22'h0;
    localparam int          STARVE_MAX_DEF  = 4;

    // SDRAM word address of a requester word; the sum wraps modulo 2^22.
    function automatic logic [21:0] sdram_word_addr(input logic [21:0] offset,
                                                    input logic [21:0] word);
        return offset + word;
    endfunction

endpackage

// File: rtl/jtlabrun_romarb_cache.sv
// One-entry read cache: the tag, 16-bit word and valid flag of the last fill.
// The hit output compares the registered tag against the live lookup address.
module jtlabrun_romarb_cache #(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inval_i,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [15:0]   fill_data_i,
    input  logic [AW-1:0] lookup_addr_i,
    output logic          hit_o,
    output logic [15:0]   data_o
);

    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [15:0]   data_q;

    // NOTE: the data word is reset along with the flags because it drives an
    // output port directly and must read as zero while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_addr_i;
            data_q  <= fill_data_i;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/jtlabrun_romarb.sv
// Shares the single SDRAM read port between the gfx fetcher and the main CPU
// ROM. Each side has a one-entry cache, and a small FSM sequences req/ack/data.
module jtlabrun_romarb
    import jtlabrun_romarb_pkg::*;
#(
    parameter int          GFX_AW      = 17,
    parameter int          MAIN_AW     = 17,
    parameter logic [21:0] GFX_OFFSET  = GFX_OFFSET_DEF,
    parameter logic [21:0] MAIN_OFFSET = MAIN_OFFSET_DEF,
    parameter int          STARVE_MAX  = STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               downloading,
    input  logic               gfx_cs,
    input  logic [GFX_AW-1:0]  gfx_addr,
    output logic [15:0]        gfx_data,
    output logic               gfx_ok,
    input  logic               main_cs,
    input  logic [MAIN_AW-1:0] main_addr,
    output logic [7:0]         main_data,
    output logic               main_ok,
    output logic               sdram_req,
    output logic [21:0]        sdram_addr,
    input  logic               sdram_ack,
    input  logic               data_rdy,
    input  logic [15:0]        data_read
);

    localparam int MWW = MAIN_AW - 1;
    localparam int IAW = (GFX_AW > MWW) ? GFX_AW : MWW;
    localparam int SW  = $clog2(STARVE_MAX + 1);

    state_e          state_q;
    owner_e          owner_q;
    logic            sdram_req_q;
    logic [21:0]     sdram_addr_q;
    logic [IAW-1:0]  issue_addr_q;
    logic [SW-1:0]   starve_q;

    logic [MWW-1:0]  main_word;
    logic            gfx_hit, main_hit, gfx_miss, main_miss;
    logic [15:0]     gfx_word, main_word_data;
    logic            fill_now, gfx_fill, main_fill;
    logic            grant_main_d;
    logic [21:0]     req_addr_d;
    logic [IAW-1:0]  issue_addr_d;

    assign main_word = main_addr[MAIN_AW-1:1];

    // The fill uses the issued address as tag, so a requester that moved on
    // while its request was in flight still misses afterwards.
    assign fill_now  = (state_q == WAIT_DATA) && data_rdy && !downloading;
    assign gfx_fill  = fill_now && (owner_q == GFX);
    assign main_fill = fill_now && (owner_q == MAIN);

    jtlabrun_romarb_cache #(.AW(GFX_AW)) u_gfx_cache (
        .clk           (clk),
        .rst           (rst),
        .inval_i       (downloading),
        .fill_i        (gfx_fill),
        .fill_addr_i   (issue_addr_q[GFX_AW-1:0]),
        .fill_data_i   (data_read),
        .lookup_addr_i (gfx_addr),
        .hit_o         (gfx_hit),
        .data_o        (gfx_word)
    );

    jtlabrun_romarb_cache #(.AW(MWW)) u_main_cache (
        .clk           (clk),
        .rst           (rst),
        .inval_i       (downloading),
        .fill_i        (main_fill),
        .fill_addr_i   (issue_addr_q[MWW-1:0]),
        .fill_data_i   (data_read),
        .lookup_addr_i (main_word),
        .hit_o         (main_hit),
        .data_o        (main_word_data)
    );

    assign gfx_ok    = gfx_cs && gfx_hit;
    assign main_ok   = main_cs && main_hit;
    assign gfx_miss  = gfx_cs && !gfx_hit;
    assign main_miss = main_cs && !main_hit;
    assign gfx_data  = gfx_word;
    assign main_data = main_addr[0] ? main_word_data[15:8] : main_word_data[7:0];

    // NOTE: every signal gets a default before the conditional logic so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_main_d = 1'b0;
        req_addr_d   = sdram_word_addr(GFX_OFFSET, 22'(gfx_addr));
        issue_addr_d = IAW'(gfx_addr);
        if (main_miss && (!gfx_miss || (starve_q >= SW'(STARVE_MAX)))) begin
            grant_main_d = 1'b1;
            req_addr_d   = sdram_word_addr(MAIN_OFFSET, 22'(main_word));
            issue_addr_d = IAW'(main_word);
        end
    end

    // NOTE: non-blocking assignments keep every register reading the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= GFX;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            issue_addr_q <= '0;
            starve_q     <= '0;
        end else if (downloading) begin
            state_q     <= IDLE;
            sdram_req_q <= 1'b0;
            starve_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gfx_miss || main_miss) begin
                        owner_q      <= grant_main_d ? MAIN : GFX;
                        sdram_addr_q <= req_addr_d;
                        issue_addr_q <= issue_addr_d;
                        sdram_req_q  <= 1'b1;
                        state_q      <= WAIT_ACK;
                        if (grant_main_d) begin
                            starve_q <= '0;
                        end else if (main_miss) begin
                            starve_q <= starve_q + SW'(1);
                        end
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req_q <= 1'b0;
                        state_q     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (data_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtlabrun_romarb.sv
// Self-checking bench for jtlabrun_romarb: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a reference model.
module tb_jtlabrun_romarb;

    localparam int unsigned GFX_OFF  = 32'h1_0000;
    localparam int unsigned MAIN_OFF = 32'h0;
    localparam int          STARVE   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        downloading = 1'b0;
    logic        gfx_cs = 1'b0;
    logic [16:0] gfx_addr = '0;
    logic [15:0] gfx_data;
    logic        gfx_ok;
    logic        main_cs = 1'b0;
    logic [16:0] main_addr = '0;
    logic [7:0]  main_data;
    logic        main_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack = 1'b0;
    logic        data_rdy = 1'b0;
    logic [15:0] data_read = '0;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    jtlabrun_romarb dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .gfx_cs      (gfx_cs),
        .gfx_addr    (gfx_addr),
        .gfx_data    (gfx_data),
        .gfx_ok      (gfx_ok),
        .main_cs     (main_cs),
        .main_addr   (main_addr),
        .main_data   (main_data),
        .main_ok     (main_ok),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-requester cache contents plus one outstanding
    // transaction (who, word, accepted yet?) and the starvation count.
    bit          m_valid [2];
    int unsigned m_tag   [2];
    int unsigned m_word  [2];
    bit          m_busy, m_acked, m_own_main, m_req;
    int unsigned m_iss, m_addr;
    int          m_starve;

    function automatic bit m_gfx_hit();
        return gfx_cs && m_valid[0] && (m_tag[0] == 32'(gfx_addr));
    endfunction

    function automatic bit m_main_hit();
        return main_cs && m_valid[1] && (m_tag[1] == 32'(main_addr >> 1));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid  = '{1'b0, 1'b0};
            m_tag    = '{0, 0};
            m_word   = '{0, 0};
            m_busy   = 1'b0;
            m_acked  = 1'b0;
            m_own_main = 1'b0;
            m_req    = 1'b0;
            m_iss    = 0;
            m_addr   = 0;
            m_starve = 0;
        end else if (downloading) begin
            m_valid  = '{1'b0, 1'b0};
            m_busy   = 1'b0;
            m_acked  = 1'b0;
            m_req    = 1'b0;
            m_starve = 0;
        end else if (!m_busy) begin
            bit gm, mm;
            gm = gfx_cs && !m_gfx_hit();
            mm = main_cs && !m_main_hit();
            if (gm || mm) begin
                m_own_main = mm && (!gm || m_starve >= STARVE);
                if (m_own_main) begin
                    m_iss    = 32'(main_addr >> 1);
                    m_addr   = (MAIN_OFF + m_iss) % (32'd1 << 22);
                    m_starve = 0;
                end else begin
                    m_iss  = 32'(gfx_addr);
                    m_addr = (GFX_OFF + m_iss) % (32'd1 << 22);
                    if (mm) m_starve++;
                end
                m_busy = 1'b1;
                m_req  = 1'b1;
            end
        end else if (!m_acked) begin
            if (sdram_ack) begin
                m_acked = 1'b1;
                m_req   = 1'b0;
            end
        end else if (data_rdy) begin
            m_valid[m_own_main] = 1'b1;
            m_tag[m_own_main]   = m_iss;
            m_word[m_own_main]  = 32'(data_read);
            m_busy  = 1'b0;
            m_acked = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_sdram_req", 32'(sdram_req), 32'(m_req));
            check("cmp_sdram_addr", 32'(sdram_addr), m_addr);
            check("cmp_gfx_ok", 32'(gfx_ok), 32'(m_gfx_hit()));
            check("cmp_main_ok", 32'(main_ok), 32'(m_main_hit()));
            check("cmp_gfx_data", 32'(gfx_data), m_word[0]);
            check("cmp_main_data", 32'(main_data),
                  main_addr[0] ? ((m_word[1] >> 8) & 32'hFF) : (m_word[1] & 32'hFF));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        for (int k = 0; k < 20 && !sdram_req; k++) tick();
        check(name, 32'(sdram_req), 32'd1);
    endtask

    task automatic serve(input logic [15:0] d);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_rdy  = 1'b0;
    endtask

    initial begin
        bit wait_data;
        bit exp_main;

        repeat (3) tick();
        check("reset_req", 32'(sdram_req), 32'd0);
        check("reset_addr", 32'(sdram_addr), 32'd0);
        check("reset_gfx_data", 32'(gfx_data), 32'd0);
        check("reset_main_data", 32'(main_data), 32'd0);
        rst = 1'b1;
        tick();
        cmp_en = 1'b1;

        // Basic gfx miss and fill.
        gfx_cs = 1'b1;
        gfx_addr = 17'h00010;
        tick();
        check("gfx_req", 32'(sdram_req), 32'd1);
        check("gfx_req_addr", 32'(sdram_addr), 32'h1_0010);
        serve(16'hBEEF);
        check("gfx_ok_after_fill", 32'(gfx_ok), 32'd1);
        check("gfx_data_after_fill", 32'(gfx_data), 32'hBEEF);

        // Main byte fetch and zero-latency byte toggle within the word.
        main_cs = 1'b1;
        main_addr = 17'h00005;
        wait_req("main_req");
        check("main_req_addr", 32'(sdram_addr), MAIN_OFF + 32'h2);
        serve(16'h12AB);
        check("main_ok_hi", 32'(main_ok), 32'd1);
        check("main_data_hi", 32'(main_data), 32'h12);
        main_addr = 17'h00004;
        #1;
        check("main_ok_lo", 32'(main_ok), 32'd1);
        check("main_data_lo", 32'(main_data), 32'hAB);
        check("main_lo_no_req", 32'(sdram_req), 32'd0);
        tick();
        check("main_lo_no_req_next", 32'(sdram_req), 32'd0);

        // Starvation: four gfx grants, then main, then the count restarts.
        main_addr = 17'h00100;
        gfx_addr  = 17'h00040;
        for (int i = 0; i < 10; i++) begin
            wait_req("starve_req");
            exp_main = (i % 5 == 4);
            check("starve_owner_addr", 32'(sdram_addr),
                  exp_main ? (MAIN_OFF + 32'(main_addr >> 1)) : (GFX_OFF + 32'(gfx_addr)));
            serve(16'($urandom));
            if (exp_main) main_addr = main_addr + 17'h100;
            else gfx_addr = gfx_addr + 17'd1;
        end

        // Address moves while the fill is in flight.
        main_cs = 1'b0;
        gfx_addr = 17'h00010;
        wait_req("move_req");
        check("move_req_addr", 32'(sdram_addr), 32'h1_0010);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        gfx_addr  = 17'h00020;
        data_rdy  = 1'b1;
        data_read = 16'h1111;
        tick();
        data_rdy = 1'b0;
        check("move_no_ok", 32'(gfx_ok), 32'd0);
        tick();
        check("move_rereq", 32'(sdram_req), 32'd1);
        check("move_rereq_addr", 32'(sdram_addr), 32'h1_0020);
        serve(16'h2222);
        check("move_ok", 32'(gfx_ok), 32'd1);
        check("move_data", 32'(gfx_data), 32'h2222);

        // Download aborts a request and flushes both caches.
        main_cs = 1'b1;
        main_addr = 17'h00300;
        wait_req("dl_req");
        check("dl_req_addr", 32'(sdram_addr), 32'h180);
        downloading = 1'b1;
        tick();
        check("dl_req_drop", 32'(sdram_req), 32'd0);
        check("dl_gfx_ok", 32'(gfx_ok), 32'd0);
        check("dl_main_ok", 32'(main_ok), 32'd0);
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        tick();
        check("dl_still_idle", 32'(sdram_req), 32'd0);
        downloading = 1'b0;
        tick();
        check("dl_refetch", 32'(sdram_req), 32'd1);
        check("dl_refetch_addr", 32'(sdram_addr), 32'h1_0020);
        serve(16'h3333);
        check("dl_refetch_ok", 32'(gfx_ok), 32'd1);

        // Asynchronous reset while waiting for data.
        wait_req("rst_req");
        check("rst_req_addr", 32'(sdram_addr), 32'h180);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_gfx_ok", 32'(gfx_ok), 32'd0);
        check("rst_main_ok", 32'(main_ok), 32'd0);
        check("rst_gfx_data", 32'(gfx_data), 32'd0);
        check("rst_main_data", 32'(main_data), 32'd0);
        data_rdy  = 1'b1;
        data_read = 16'h4444;
        tick();
        data_rdy = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_no_fill_main", 32'(main_ok), 32'd0);
        check("rst_no_fill_data", 32'(main_data), 32'd0);
        tick();
        check("rst_refetch", 32'(sdram_req), 32'd1);

        // Randomized traffic against the model.
        wait_data = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom % 4 == 0) gfx_cs = 1'($urandom % 2);
            if ($urandom % 4 == 0) gfx_addr = ($urandom % 6 == 0) ? 17'h1FFFF : 17'($urandom % 8);
            if ($urandom % 4 == 0) main_cs = 1'($urandom % 2);
            if ($urandom % 3 == 0) main_addr = 17'($urandom % 16);
            downloading = ($urandom % 80 == 0);
            sdram_ack = (sdram_req && ($urandom % 3 == 0)) || ($urandom % 40 == 0);
            if (sdram_req && sdram_ack) wait_data = 1'b1;
            data_rdy = (wait_data && ($urandom % 3 == 0)) || ($urandom % 40 == 0);
            if (data_rdy || downloading) wait_data = 1'b0;
            data_read = 16'($urandom);
            tick();
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
